// File: rtl/rr_select_arbiter.sv
// rr_select_arbiter: four-requester round-robin arbiter that drives the
// A/B select pair of a downstream 2-to-4 decoder. It grants one requester
// at a time and releases on done, on a dropped request, or on a hold watchdog.
// There is always a one-cycle idle gap between grants, so the select
// never changes while grant_valid is high.
module rr_select_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       A,
  output logic       B,
  output logic       grant_valid,
  output logic       timeout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0] state;
  logic [1:0] last;
  logic [1:0] sel;
  logic [7:0] hold_cnt;

  logic       pick_vld;
  logic [1:0] pick;
  logic       rel_done;
  logic       rel_drop;
  logic       rel_wd;

  // Round-robin search starting at last+1. The loop runs from the farthest
  // offset (4, i.e. last itself) down to the nearest, so the nearest hit wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      if (req[last + 2'(i)]) begin
        pick_vld = 1'b1;
        pick     = last + 2'(i);
      end
    end
  end

  // Release causes while holding a grant
  always_comb begin
    rel_done = done;
    rel_drop = !req[last];
    rel_wd   = (hold_cnt == HOLD_LAST);
  end

  // Grant sequencing: IDLE picks a winner, BUSY holds it until a release
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 2'd3;
      sel         <= 2'd0;
      hold_cnt    <= 8'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          grant_valid <= 1'b0;
          if (pick_vld) begin
            sel         <= pick;
            last        <= pick;
            hold_cnt    <= 8'd0;
            grant_valid <= 1'b1;
            state       <= BUSY;
          end
        end
        default: begin
          if (rel_done || rel_drop || rel_wd) begin
            grant_valid <= 1'b0;
            state       <= IDLE;
            // Flag the watchdog only when nothing else would have released
            timeout     <= rel_wd && !rel_done && !rel_drop;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign A = sel[1];
  assign B = sel[0];

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Bench for rr_select_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model. Two instances share the inputs,
// one with the default hold limit and one with MAX_HOLD = 4.
module tb_rr_select_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       a16, b16, gv16, to16;
  logic       a4, b4, gv4, to4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_select_arbiter #(.MAX_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .A(a16), .B(b16), .grant_valid(gv16), .timeout(to16)
  );

  rr_select_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .A(a4), .B(b4), .grant_valid(gv4), .timeout(to4)
  );

  // Reference model: who owns the resource, for how long, and what is shown
  typedef struct {
    bit busy;
    int owner;   // most recent grant index
    int held;    // cycles already spent in this grant, minus one
    int shown;   // index on A/B
    bit gv;
    bit to;
  } model_t;

  model_t m16, m4;

  function automatic model_t model_reset();
    model_t m;
    m.busy = 0; m.owner = 3; m.held = 0; m.shown = 0; m.gv = 0; m.to = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, bit rn, bit [3:0] r, bit d, int max_hold);
    model_t n = m;
    if (!rn) return model_reset();
    n.to = 0;
    if (!m.busy) begin
      n.gv = 0;
      for (int off = 1; off <= 4; off++) begin
        int k = (m.owner + off) % 4;
        if (r[k]) begin
          n.busy = 1; n.owner = k; n.shown = k; n.held = 0; n.gv = 1;
          break;
        end
      end
    end else begin
      bit dropped = (r[m.owner] == 1'b0);
      bit expired = (m.held + 1 >= max_hold);
      if (d || dropped || expired) begin
        n.busy = 0; n.gv = 0;
        n.to = expired && !d && !dropped;
      end else begin
        n.held = m.held + 1;
      end
    end
    return n;
  endfunction

  // Advance one clock; both models track the DUTs, outputs settle 1ns later
  task automatic step();
    @(posedge clk);
    m16 = model_step(m16, rst_n, req, done, 16);
    m4  = model_step(m4,  rst_n, req, done, 4);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0000; done = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_chk++;
      if ({a16, b16, gv16, to16} !== 4'b0000 || {a4, b4, gv4, to4} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got A,B,gv,to=%b%b%b%b / %b%b%b%b want 0000", c,
                 a16, b16, gv16, to16, a4, b4, gv4, to4);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rotation();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      done = 1'b0;
      step();
      n_chk++;
      if (gv16 !== 1'b1 || {a16, b16} !== 2'(g % 4)) begin
        n_fail++;
        $display("FAIL rotation grant%0d: got gv=%b sel=%b%b want gv=1 sel=%0d", g, gv16, a16, b16, g % 4);
      end
      done = 1'b1;
      step();
      n_chk++;
      if (gv16 !== 1'b0 || to16 !== 1'b0) begin
        n_fail++;
        $display("FAIL rotation release%0d: got gv=%b to=%b want 0 0", g, gv16, to16);
      end
    end
    done = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    step();
    n_chk++;
    if ({a16, b16, gv16} !== 3'b101) begin
      n_fail++;
      $display("FAIL single grant: got A,B,gv=%b%b%b want 101", a16, b16, gv16);
    end
    req = 4'b0000;
    step();
    n_chk++;
    if (gv16 !== 1'b0 || to16 !== 1'b0 || {a16, b16} !== 2'b10) begin
      n_fail++;
      $display("FAIL single drop: got gv=%b to=%b sel=%b%b want gv=0 to=0 sel=10", gv16, to16, a16, b16);
    end
  endtask

  task automatic test_watchdog();
    int hi;
    do_reset();
    req = 4'b0010;
    step();
    hi = (gv16 === 1'b1) ? 1 : 0;
    for (int c = 0; c < 40 && gv16 === 1'b1; c++) begin
      step();
      if (gv16 === 1'b1) hi++;
    end
    n_chk++;
    if (hi != 16 || to16 !== 1'b1) begin
      n_fail++;
      $display("FAIL watchdog hold: got %0d cycles to=%b want 16 cycles to=1", hi, to16);
    end
    step();
    n_chk++;
    if (gv16 !== 1'b1 || {a16, b16} !== 2'b01 || to16 !== 1'b0) begin
      n_fail++;
      $display("FAIL watchdog regrant: got gv=%b sel=%b%b to=%b want gv=1 sel=01 to=0", gv16, a16, b16, to16);
    end
  endtask

  task automatic test_collision();
    do_reset();
    req = 4'b0001;
    step();                       // first BUSY cycle
    for (int c = 0; c < 3; c++) begin
      step();                     // BUSY cycles 2..4
      n_chk++;
      if (gv4 !== 1'b1) begin
        n_fail++;
        $display("FAIL collision hold%0d: got gv4=%b want 1", c + 2, gv4);
      end
    end
    done = 1'b1;
    step();
    done = 1'b0;
    n_chk++;
    if (gv4 !== 1'b0 || to4 !== 1'b0) begin
      n_fail++;
      $display("FAIL collision release: got gv4=%b to4=%b want 0 0", gv4, to4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1000;
    step();
    n_chk++;
    if ({a16, b16, gv16} !== 3'b111) begin
      n_fail++;
      $display("FAIL resetmid grant3: got A,B,gv=%b%b%b want 111", a16, b16, gv16);
    end
    rst_n = 1'b0; req = 4'b1001;
    step();
    n_chk++;
    if ({a16, b16, gv16, to16} !== 4'b0000) begin
      n_fail++;
      $display("FAIL resetmid clear: got A,B,gv,to=%b%b%b%b want 0000", a16, b16, gv16, to16);
    end
    rst_n = 1'b1;
    step();
    n_chk++;
    if ({a16, b16, gv16} !== 3'b001) begin
      n_fail++;
      $display("FAIL resetmid next: got A,B,gv=%b%b%b want 001", a16, b16, gv16);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) req = req | 4'(1 << $urandom_range(0, 3));
      done  = ($urandom_range(0, 5) == 0);
      rst_n = ($urandom_range(0, 60) != 0);
      step();
      n_chk++;
      if ({a16, b16} !== 2'(m16.shown) || gv16 !== m16.gv || to16 !== m16.to ||
          {a4, b4} !== 2'(m4.shown) || gv4 !== m4.gv || to4 !== m4.to) begin
        n_fail++;
        $display("FAIL random cyc%0d: got16 sel=%b%b gv=%b to=%b want sel=%0d gv=%b to=%b; got4 sel=%b%b gv=%b to=%b want sel=%0d gv=%b to=%b",
                 c, a16, b16, gv16, to16, m16.shown, m16.gv, m16.to,
                 a4, b4, gv4, to4, m4.shown, m4.gv, m4.to);
      end
    end
    rst_n = 1'b1; done = 1'b0;
  endtask

  initial begin
    m16 = model_reset();
    m4  = model_reset();
    rst_n = 1'b0; req = 4'b0000; done = 1'b0;
    test_reset();
    test_rotation();
    test_single();
    test_watchdog();
    test_collision();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_select_arbiter.md
# rr_select_arbiter

Four-requester round-robin arbiter that produces the 2-bit select pair `A`/`B` consumed directly by the downstream `twotofourdecoder`. The decoder expands the select into a one-hot grant/enable. The arbiter owns the sequencing: which requester is granted, for how long, and when the grant is released. It supports a rotating priority pointer, a release handshake, and a hold-timeout watchdog.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum consecutive cycles a single grant may stay valid. Legal range 1..255.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `req`  in  4  request vector; `req[k]` high means requester k wants the resource.
- `done`  in  1  release pulse from the current owner; sampled only while `grant_valid` = 1.
- `A`  out  1  select MSB (granted index bit 1); drives decoder input `A`.
- `B`  out  1  select LSB (granted index bit 0); drives decoder input `B`.
- `grant_valid`  out  1  high while `A`/`B` name an active grant.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly released by the watchdog.

## Operation
- State machine with two states, IDLE and BUSY. All outputs are registered.
- Internal state:
  - `last[1:0]`: index of the most recent grant.
  - `hold_cnt[7:0]`: cycles elapsed in the current grant.
- Reset (`rst_n` = 0 at an edge):
  - state = IDLE, `last` = 3, `hold_cnt` = 0.
  - `A` = 0, `B` = 0, `grant_valid` = 0, `timeout` = 0.
- IDLE:
  - If `req` = 0, stay in IDLE and leave outputs unchanged except `grant_valid` = 0.
  - Otherwise pick the first k with `req[k]` = 1, searching `last+1`, `last+2`, `last+3`, `last+4` (mod 4).
  - Load `{A,B}` = k, `last` = k, `grant_valid` = 1, `hold_cnt` = 0; go to BUSY.
- BUSY: release at the current edge if any of the following holds:
  - (a) `done` = 1;
  - (b) `req[last]` = 0;
  - (c) `hold_cnt` = `MAX_HOLD`-1.
- On release: `grant_valid` = 0 and go to IDLE.
  - `timeout` = 1 for that one cycle only when (c) is the sole cause, i.e. (a) and (b) are both false.
- If there is no release, `hold_cnt` increments (8-bit, never wraps because `MAX_HOLD` ≤ 255).
- `A`/`B` hold the last granted index while `grant_valid` = 0. Consumers must qualify the select with `grant_valid`.
- `done` is ignored in IDLE.
- Changes to `req` bits other than `req[last]` during BUSY have no effect until the next IDLE evaluation.

## Timing
- Grant latency: `req` sampled high in IDLE at edge N → `grant_valid`/`A`/`B` valid after edge N (one cycle from request to grant).
- Grant duration:
  - minimum 1 cycle (`done` high at the first BUSY edge);
  - maximum exactly `MAX_HOLD` cycles.
- Release at edge M → `grant_valid` low after M. The next grant occurs at the earliest after edge M+1, giving a mandatory one-cycle gap between grants. The downstream decoder therefore never sees a select change while `grant_valid` is high.
- `timeout` is high for exactly the one cycle following the release edge, coincident with `grant_valid` = 0.
- Fairness: with all four requests continuously asserted, grants rotate 0,1,2,3,0,…
- A sole requester is re-granted after the one-cycle gap, including after a timeout.
- Reset mid-BUSY: at the next edge with `rst_n` = 0, all outputs take their reset values and the pointer returns to `last` = 3. The following grant favours index 0.
- Simultaneous `done` and timeout condition: normal release, `timeout` = 0.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `req` = 4'b1111 → `A`=0, `B`=0, `grant_valid`=0, `timeout`=0 throughout.
- Rotation: `req` = 4'b1111, pulse `done` on each grant's first cycle → `{A,B}` sequence 00,01,10,11,00. Each grant lasts 1 cycle, followed by 1 idle cycle.
- Single requester: `req` = 4'b0100 after reset → one cycle later `A`=1, `B`=0, `grant_valid`=1. Drop `req[2]` → `grant_valid`=0 next edge, `timeout`=0.
- Watchdog: `MAX_HOLD`=16, `req` = 4'b0010 held, `done`=0 → `grant_valid` high exactly 16 cycles, `timeout` pulses 1 cycle, then `{A,B}`=01 is re-granted after a 1-cycle gap.
- Done/timeout collision: `MAX_HOLD`=4, assert `done` on the 4th BUSY cycle → release with `timeout`=0.
- Reset mid-grant: grant index 3 active, assert `rst_n`=0 for 1 cycle with `req`=4'b1001 → outputs clear. After reset is released, the first grant is `{A,B}`=00.
